// File: rtl/count_date_pkg.sv
// Shared calendar constants and the leap-year rule used by the date counter
// and its month-length lookup.
package count_date_pkg;

  localparam logic [4:0] DAY_FIRST = 5'd1;
  localparam logic [3:0] MON_FIRST = 4'd1;
  localparam logic [3:0] MON_LAST  = 4'd12;

  localparam logic [4:0] LEN_28 = 5'd28;
  localparam logic [4:0] LEN_29 = 5'd29;
  localparam logic [4:0] LEN_30 = 5'd30;
  localparam logic [4:0] LEN_31 = 5'd31;

  // Two-digit years map to 2000+yr, so every multiple of 4 (including 0) is leap.
  function automatic logic is_leap(input logic [6:0] yr);
    return (yr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/count_date_days_in_month.sv
// Combinational month-length lookup; invalid months report length 0 so that
// no day can ever be accepted against them.
module days_in_month
  import count_date_pkg::*;
(
  input  logic [3:0] month,
  input  logic [6:0] year,
  output logic [4:0] length
);

  always_comb begin
    length = 5'd0;
    case (month)
      4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10, 4'd12: length = LEN_31;
      4'd4, 4'd6, 4'd9, 4'd11:                     length = LEN_30;
      4'd2:    length = is_leap(year) ? LEN_29 : LEN_28;
      default: length = 5'd0;
    endcase
  end

endmodule

// File: rtl/count_date.sv
// Day/month/year calendar counter advanced by a daily carry strobe, with a
// validated synchronous load that takes priority over the carry.
module count_date
  import count_date_pkg::*;
#(
  parameter int YEAR_MAX = 99
) (
  input  logic       clk,
  input  logic       set_d,
  input  logic       pulse_d,
  input  logic       load,
  input  logic [4:0] load_day,
  input  logic [3:0] load_mon,
  input  logic [6:0] load_yr,
  output logic [4:0] cnt_day,
  output logic [3:0] cnt_mon,
  output logic [6:0] cnt_yr,
  output logic       pulse_y,
  output logic       load_err
);

  localparam logic [6:0] YR_MAX = 7'(YEAR_MAX);

  logic [4:0] cnt_day_q, cnt_day_d;
  logic [3:0] cnt_mon_q, cnt_mon_d;
  logic [6:0] cnt_yr_q,  cnt_yr_d;
  logic       pulse_y_q, pulse_y_d;
  logic       load_err_q, load_err_d;

  logic [4:0] cur_len;
  logic [4:0] ld_len;
  logic       load_ok;

  days_in_month u_len_cur (
    .month  (cnt_mon_q),
    .year   (cnt_yr_q),
    .length (cur_len)
  );

  days_in_month u_len_ld (
    .month  (load_mon),
    .year   (load_yr),
    .length (ld_len)
  );

  // Month range is checked explicitly even though ld_len is 0 for bad months.
  assign load_ok = (load_mon >= MON_FIRST) && (load_mon <= MON_LAST) &&
                   (load_yr <= YR_MAX) &&
                   (load_day >= DAY_FIRST) && (load_day <= ld_len);

  always_comb begin
    cnt_day_d  = cnt_day_q;
    cnt_mon_d  = cnt_mon_q;
    cnt_yr_d   = cnt_yr_q;
    pulse_y_d  = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      // A carry arriving with a load is dropped, not deferred.
      if (load_ok) begin
        cnt_day_d = load_day;
        cnt_mon_d = load_mon;
        cnt_yr_d  = load_yr;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (pulse_d) begin
      if (cnt_day_q < cur_len) begin
        cnt_day_d = cnt_day_q + 5'd1;
      end else begin
        cnt_day_d = DAY_FIRST;
        if (cnt_mon_q < MON_LAST) begin
          cnt_mon_d = cnt_mon_q + 4'd1;
        end else begin
          cnt_mon_d = MON_FIRST;
          if (cnt_yr_q < YR_MAX) begin
            cnt_yr_d = cnt_yr_q + 7'd1;
          end else begin
            cnt_yr_d  = 7'd0;
            pulse_y_d = 1'b1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge set_d) begin
    if (!set_d) begin
      cnt_day_q  <= DAY_FIRST;
      cnt_mon_q  <= MON_FIRST;
      cnt_yr_q   <= 7'd0;
      pulse_y_q  <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      cnt_day_q  <= cnt_day_d;
      cnt_mon_q  <= cnt_mon_d;
      cnt_yr_q   <= cnt_yr_d;
      pulse_y_q  <= pulse_y_d;
      load_err_q <= load_err_d;
    end
  end

  assign cnt_day  = cnt_day_q;
  assign cnt_mon  = cnt_mon_q;
  assign cnt_yr   = cnt_yr_q;
  assign pulse_y  = pulse_y_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_count_date.sv
// Randomized and directed bench for count_date against a calendar-arithmetic
// reference model.
module tb_count_date;

  logic       clk;
  logic       set_d;
  logic       pulse_d;
  logic       load;
  logic [4:0] load_day;
  logic [3:0] load_mon;
  logic [6:0] load_yr;
  logic [4:0] cnt_day;
  logic [3:0] cnt_mon;
  logic [6:0] cnt_yr;
  logic       pulse_y;
  logic       load_err;

  int checks   = 0;
  int failures = 0;

  int m_day, m_mon, m_yr, m_py, m_le;

  count_date #(.YEAR_MAX(99)) dut (
    .clk      (clk),
    .set_d    (set_d),
    .pulse_d  (pulse_d),
    .load     (load),
    .load_day (load_day),
    .load_mon (load_mon),
    .load_yr  (load_yr),
    .cnt_day  (cnt_day),
    .cnt_mon  (cnt_mon),
    .cnt_yr   (cnt_yr),
    .pulse_y  (pulse_y),
    .load_err (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int mlen(input int m, input int y);
    if (m == 2) return ((y % 4) == 0) ? 29 : 28;
    if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
    if (m >= 1 && m <= 12) return 31;
    return 0;
  endfunction

  task automatic model_reset();
    m_day = 1; m_mon = 1; m_yr = 0; m_py = 0; m_le = 0;
  endtask

  // Reference: what the calendar should read after one edge with these inputs.
  task automatic model_step(input int pd, input int ld, input int d, input int m, input int y);
    m_py = 0;
    m_le = 0;
    if (ld != 0) begin
      if (m >= 1 && m <= 12 && y <= 99 && d >= 1 && d <= mlen(m, y)) begin
        m_day = d; m_mon = m; m_yr = y;
      end else begin
        m_le = 1;
      end
    end else if (pd != 0) begin
      int days_total;
      days_total = m_day + 1;
      if (days_total > mlen(m_mon, m_yr)) begin
        m_day = 1;
        m_mon = m_mon + 1;
        if (m_mon > 12) begin
          m_mon = 1;
          m_yr  = m_yr + 1;
          if (m_yr > 99) begin
            m_yr = 0;
            m_py = 1;
          end
        end
      end else begin
        m_day = days_total;
      end
    end
  endtask

  // Applies one clock of stimulus, then samples 1 time unit after the edge.
  task automatic drive(input int pd, input int ld, input int d, input int m, input int y);
    pulse_d  = (pd != 0);
    load     = (ld != 0);
    load_day = 5'(d);
    load_mon = 4'(m);
    load_yr  = 7'(y);
    @(posedge clk);
    #1;
    model_step(pd, ld, d, m, y);
    pulse_d = 1'b0;
    load    = 1'b0;
  endtask

  task automatic test_reset();
    set_d = 1'b0; pulse_d = 1'b1; load = 1'b1;
    load_day = 5'd9; load_mon = 4'd9; load_yr = 7'd9;
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    checks++;
    if ({cnt_day, cnt_mon, cnt_yr, pulse_y, load_err} !== {5'd1, 4'd1, 7'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_state got %0d/%0d/%0d py=%b le=%b want 1/1/0 py=0 le=0",
               cnt_day, cnt_mon, cnt_yr, pulse_y, load_err);
    end
    pulse_d = 1'b0; load = 1'b0;
    @(negedge clk);
    set_d = 1'b1;
    drive(0, 0, 0, 0, 0);
    checks++;
    if ({cnt_day, cnt_mon, cnt_yr} !== {5'd1, 4'd1, 7'd0}) begin
      failures++;
      $display("FAIL reset_release_idle got %0d/%0d/%0d want 1/1/0", cnt_day, cnt_mon, cnt_yr);
    end
  endtask

  task automatic test_count_31();
    for (int i = 1; i <= 31; i++) begin
      drive(1, 0, 0, 0, 0);
      checks++;
      if (cnt_day !== 5'(m_day) || cnt_mon !== 4'(m_mon)) begin
        failures++;
        $display("FAIL count31_step%0d got %0d/%0d want %0d/%0d", i, cnt_day, cnt_mon, m_day, m_mon);
      end
    end
    checks++;
    if ({cnt_day, cnt_mon, cnt_yr} !== {5'd1, 4'd2, 7'd0}) begin
      failures++;
      $display("FAIL count31_final got %0d/%0d/%0d want 1/2/0", cnt_day, cnt_mon, cnt_yr);
    end
  endtask

  task automatic test_leap();
    drive(0, 1, 28, 2, 1);
    drive(1, 0, 0, 0, 0);
    checks++;
    if ({cnt_day, cnt_mon, cnt_yr} !== {5'd1, 4'd3, 7'd1}) begin
      failures++;
      $display("FAIL nonleap_feb got %0d/%0d/%0d want 1/3/1", cnt_day, cnt_mon, cnt_yr);
    end
    drive(0, 1, 28, 2, 4);
    drive(1, 0, 0, 0, 0);
    checks++;
    if ({cnt_day, cnt_mon, cnt_yr} !== {5'd29, 4'd2, 7'd4}) begin
      failures++;
      $display("FAIL leap_feb29 got %0d/%0d/%0d want 29/2/4", cnt_day, cnt_mon, cnt_yr);
    end
    drive(1, 0, 0, 0, 0);
    checks++;
    if ({cnt_day, cnt_mon, cnt_yr} !== {5'd1, 4'd3, 7'd4}) begin
      failures++;
      $display("FAIL leap_mar1 got %0d/%0d/%0d want 1/3/4", cnt_day, cnt_mon, cnt_yr);
    end
  endtask

  task automatic test_century();
    drive(0, 1, 31, 12, 99);
    checks++;
    if (pulse_y !== 1'b0 || load_err !== 1'b0) begin
      failures++;
      $display("FAIL century_load_strobes got py=%b le=%b want 0 0", pulse_y, load_err);
    end
    drive(1, 0, 0, 0, 0);
    checks++;
    if ({cnt_day, cnt_mon, cnt_yr, pulse_y} !== {5'd1, 4'd1, 7'd0, 1'b1}) begin
      failures++;
      $display("FAIL century_wrap got %0d/%0d/%0d py=%b want 1/1/0 py=1",
               cnt_day, cnt_mon, cnt_yr, pulse_y);
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (pulse_y !== 1'b0) begin
      failures++;
      $display("FAIL century_strobe_clear got py=%b want 0", pulse_y);
    end
  endtask

  task automatic test_invalid_load();
    int bad_d[3] = '{31, 29, 10};
    int bad_m[3] = '{4, 2, 13};
    int bad_y[3] = '{5, 3, 5};
    drive(0, 1, 17, 8, 42);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, bad_d[i], bad_m[i], bad_y[i]);
      checks++;
      if ({cnt_day, cnt_mon, cnt_yr, load_err} !== {5'd17, 4'd8, 7'd42, 1'b1}) begin
        failures++;
        $display("FAIL invalid_load%0d got %0d/%0d/%0d le=%b want 17/8/42 le=1",
                 i, cnt_day, cnt_mon, cnt_yr, load_err);
      end
      drive(0, 0, 0, 0, 0);
      checks++;
      if (load_err !== 1'b0) begin
        failures++;
        $display("FAIL invalid_load%0d_clear got le=%b want 0", i, load_err);
      end
    end
    drive(0, 1, 5, 3, 100);
    checks++;
    if ({cnt_day, cnt_mon, cnt_yr, load_err} !== {5'd17, 4'd8, 7'd42, 1'b1}) begin
      failures++;
      $display("FAIL invalid_year got %0d/%0d/%0d le=%b want 17/8/42 le=1",
               cnt_day, cnt_mon, cnt_yr, load_err);
    end
  endtask

  task automatic test_load_priority();
    drive(0, 1, 30, 6, 10);
    drive(1, 1, 15, 6, 10);
    checks++;
    if ({cnt_day, cnt_mon, cnt_yr, pulse_y, load_err} !== {5'd15, 4'd6, 7'd10, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL load_priority got %0d/%0d/%0d py=%b le=%b want 15/6/10 py=0 le=0",
               cnt_day, cnt_mon, cnt_yr, pulse_y, load_err);
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (cnt_day !== 5'd15) begin
      failures++;
      $display("FAIL load_priority_not_deferred got day=%0d want 15", cnt_day);
    end
  endtask

  task automatic test_async_reset();
    drive(0, 1, 20, 7, 30);
    load = 1'b1; load_day = 5'd3; load_mon = 4'd3; load_yr = 7'd3;
    #2;
    set_d = 1'b0;
    #1;
    model_reset();
    checks++;
    if ({cnt_day, cnt_mon, cnt_yr, pulse_y, load_err} !== {5'd1, 4'd1, 7'd0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL async_reset got %0d/%0d/%0d py=%b le=%b want 1/1/0 py=0 le=0",
               cnt_day, cnt_mon, cnt_yr, pulse_y, load_err);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({cnt_day, cnt_mon, cnt_yr} !== {5'd1, 4'd1, 7'd0}) begin
      failures++;
      $display("FAIL async_reset_hold got %0d/%0d/%0d want 1/1/0", cnt_day, cnt_mon, cnt_yr);
    end
    load = 1'b0;
    @(negedge clk);
    set_d = 1'b1;
    drive(1, 0, 0, 0, 0);
    checks++;
    if ({cnt_day, cnt_mon, cnt_yr} !== {5'd2, 4'd1, 7'd0}) begin
      failures++;
      $display("FAIL async_reset_resume got %0d/%0d/%0d want 2/1/0", cnt_day, cnt_mon, cnt_yr);
    end
  endtask

  task automatic test_random();
    int pd, ld, d, m, y;
    for (int i = 0; i < 400; i++) begin
      pd = ($urandom_range(0, 3) != 0) ? 1 : 0;
      ld = ($urandom_range(0, 9) == 0) ? 1 : 0;
      d  = $urandom_range(0, 31);
      m  = $urandom_range(0, 13);
      y  = ($urandom_range(0, 3) == 0) ? $urandom_range(95, 110) : $urandom_range(0, 99);
      drive(pd, ld, d, m, y);
      checks++;
      if ({cnt_day, cnt_mon, cnt_yr, pulse_y, load_err} !==
          {5'(m_day), 4'(m_mon), 7'(m_yr), 1'(m_py), 1'(m_le)}) begin
        failures++;
        $display("FAIL random%0d got %0d/%0d/%0d py=%b le=%b want %0d/%0d/%0d py=%0d le=%0d",
                 i, cnt_day, cnt_mon, cnt_yr, pulse_y, load_err, m_day, m_mon, m_yr, m_py, m_le);
      end
    end
  endtask

  initial begin
    set_d = 1'b0; pulse_d = 1'b0; load = 1'b0;
    load_day = 5'd0; load_mon = 4'd0; load_yr = 7'd0;
    model_reset();
    test_reset();
    test_count_31();
    test_leap();
    test_century();
    test_invalid_load();
    test_load_priority();
    test_async_reset();
    drive(0, 1, 31, 12, 99);
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/count_date.md
COUNT_DATE -- requirements
Module: count_date

Interface
REQ-001 Parameter YEAR_MAX, default 99, meaning: last year value before wrap to 0 (two-digit year 2000+yr).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 set_d  input  1  reset, asynchronous, active-low.
REQ-004 pulse_d  input  1  day-carry strobe from the hour counter; one clk wide per day rollover.
REQ-005 load  input  1  single-cycle request to overwrite the date with load_day/load_mon/load_yr.
REQ-006 load_day  input  5  requested day of month, 1..31.
REQ-007 load_mon  input  4  requested month, 1..12.
REQ-008 load_yr  input  7  requested year, 0..YEAR_MAX.
REQ-009 cnt_day  output  5  current day of month, registered.
REQ-010 cnt_mon  output  4  current month, registered.
REQ-011 cnt_yr  output  7  current year, registered.
REQ-012 pulse_y  output  1  registered century-carry strobe, high one cycle when year wraps YEAR_MAX -> 0.
REQ-013 load_err  output  1  registered strobe, high one cycle when a load request is rejected.

Function
REQ-014 Month length: 31 for months 1,3,5,7,8,10,12; 30 for 4,6,9,11; February 29 when yr mod 4 == 0, else 28 (yr 0 is leap).
REQ-015 pulse_d=1, load=0, cnt_day < month length: cnt_day increments by 1 on next edge; month and year hold.
REQ-016 pulse_d=1, load=0, cnt_day == month length: cnt_day -> 1, cnt_mon increments.
REQ-017 Same as REQ-016 with cnt_mon == 12: cnt_mon -> 1, cnt_yr increments.
REQ-018 Same as REQ-017 with cnt_yr == YEAR_MAX: cnt_yr -> 0, pulse_y = 1 on the same edge as the wrap.
REQ-019 pulse_d=0, load=0: all counters hold; pulse_y and load_err 0.
REQ-020 Load valid when 1 <= load_mon <= 12, load_yr <= YEAR_MAX, 1 <= load_day <= month length of (load_mon, load_yr).
REQ-021 Valid load: counters take load values on next edge; load_err=0; pulse_y=0.
REQ-022 Invalid load: counters hold; load_err=1 for exactly that one cycle.
REQ-023 load and pulse_d in same cycle: load wins; pulse_d is discarded (not deferred); no pulse_y.
REQ-024 Latency: every output reflects inputs of the previous edge (one cycle); no combinational input-to-output path.
REQ-025 Counters never hold an illegal date; out-of-range state unreachable except via X at power-up, which reset clears.
REQ-026 Strobes pulse_y and load_err return to 0 on the following edge unless retriggered.

Reset
REQ-027 set_d low asynchronously forces cnt_day=1, cnt_mon=1, cnt_yr=0, pulse_y=0, load_err=0, regardless of clk.
REQ-028 While set_d low, pulse_d and load are ignored; first possible update is the first rising clk after set_d deasserts.
REQ-029 Reset asserted mid-operation (e.g. during a load cycle) discards the pending update entirely.

Structure
REQ-030 Shared package holds month-length constants (28/29/30/31), month range constants (1, 12), and the leap-year rule as a function.
REQ-031 One combinational sub-module days_in_month (inputs month 4b, year 7b; output length 5b), instantiated twice: current date and load request.
REQ-032 Top level contains only the three counter registers, two strobe registers, and priority/carry logic.

Verification
REQ-033 Reset then 31 pulse_d -> date 1/2/0 after 31st pulse; cnt_day sequence 1..31 then 1.
REQ-034 Load 28/2/1, then pulse_d -> 1/3/1; load 28/2/4, pulse_d -> 29/2/4, pulse_d -> 1/3/4.
REQ-035 Load 31/12/99, pulse_d -> 1/1/0 with pulse_y=1 one cycle, 0 next cycle.
REQ-036 Load 31/4/5 (invalid), also 29/2/3 and mon 13 -> date unchanged, load_err=1 one cycle each.
REQ-037 load 15/6/10 with pulse_d same cycle from 30/6/10 -> 15/6/10, no month increment.
REQ-038 set_d pulsed low between clk edges during date 20/7/30 -> outputs 1/1/0 immediately, strobes 0.
